// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, transaction owner and the
// width of the data-streak counter used for the fetch starvation bound.
package mem_arb_pkg;

  localparam int unsigned StreakW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } arb_state_e;

  typedef enum logic {
    OwnIf,
    OwnD
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time,
// data-first with a bounded streak so fetch cannot starve; killed fetch responses are dropped.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_kill,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,

  output logic                  m_valid,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_ready,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam logic [StreakW-1:0] MaxStreak = StreakW'(MAX_DATA_STREAK);
  localparam logic [StreakW-1:0] StreakSat = '1;

  arb_state_e           state_q;
  owner_e               owner_q;
  logic [StreakW-1:0]   streak_q;
  logic                 kill_q;

  logic                 pick_if;
  logic                 grant;
  logic                 resp;
  logic                 kill_hit;

  // Fetch only overtakes a pending data request once the data streak has hit its bound.
  always_comb begin
    pick_if = if_req && (!d_req || (streak_q == MaxStreak));
    grant   = !reset && (state_q == StIdle) && (if_req || d_req);
    if_gnt  = grant && pick_if;
    d_gnt   = grant && !pick_if;
  end

  assign kill_hit = if_kill && (owner_q == OwnIf) && (state_q != StIdle);

  // A kill arriving in the response cycle itself must still swallow the response.
  always_comb begin
    resp      = !reset && (state_q == StWait) && m_rvalid;
    if_rvalid = resp && (owner_q == OwnIf) && !kill_q && !kill_hit;
    d_rvalid  = resp && (owner_q == OwnD);
    if_rdata  = if_rvalid ? m_rdata : '0;
    d_rdata   = (d_rvalid && !m_we) ? m_rdata : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= OwnIf;
      streak_q <= '0;
      kill_q   <= 1'b0;
      m_valid  <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            m_valid <= 1'b1;
            state_q <= StIssue;
            if (pick_if) begin
              owner_q  <= OwnIf;
              m_we     <= 1'b0;
              m_addr   <= if_addr;
              m_wdata  <= '0;
              m_wstrb  <= '0;
              streak_q <= '0;
            end else begin
              owner_q <= OwnD;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_wstrb <= d_wstrb;
              if (!if_req) begin
                streak_q <= '0;
              end else if (streak_q != StreakSat) begin
                streak_q <= streak_q + StreakW'(1);
              end
            end
          end
        end
        StIssue: begin
          if (kill_hit) kill_q <= 1'b1;
          if (m_ready) begin
            m_valid <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (m_rvalid) begin
            state_q <= StIdle;
            kill_q  <= 1'b0;
          end else if (kill_hit) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a behavioural memory and reference model.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef struct packed {
    logic        is_if;
    logic [31:0] data;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_kill = 1'b0, if_gnt, if_rvalid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [3:0]  d_wstrb = '0;
  logic        m_valid, m_we, m_ready = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata = '0;
  logic [3:0]  m_wstrb;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs (written by the main sequence only).
  bit          auto_if = 0, auto_d = 0, auto_kill = 0;
  int unsigned if_pct = 0, d_pct = 0, kill_pct = 0, rdy_pct = 100;
  int unsigned resp_min = 1, resp_max = 1;
  int          stall_k = -1;
  int          kill_cnt = 0;
  logic [31:0] if_todo[$];
  cmd_t        d_todo[$];

  // Reference memory image and the behavioural memory's own storage.
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] mem_arr[int unsigned];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_arr.exists(a >> 2) ? mem_arr[a >> 2] : init_word(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(63)) << 2;
  endfunction

  // ---------------- requesters ----------------
  logic g_if = 1'b0, g_d = 1'b0;
  int   kill_done = 0;

  always @(posedge clock) begin
    #1;
    if (reset) begin
      if_req  = 1'b0;
      d_req   = 1'b0;
      if_kill = 1'b0;
    end else begin
      if (if_req && g_if) if_req = 1'b0;
      if (!if_req) begin
        if (if_todo.size() > 0) begin
          if_addr = if_todo.pop_front();
          if_req  = 1'b1;
        end else if (auto_if && ($urandom_range(99) < if_pct)) begin
          if_addr = rand_addr();
          if_req  = 1'b1;
        end
      end
      if (d_req && g_d) d_req = 1'b0;
      if (!d_req) begin
        if (d_todo.size() > 0) begin
          cmd_t c;
          c = d_todo.pop_front();
          {d_we, d_addr, d_wdata, d_wstrb} = c;
          d_req = 1'b1;
        end else if (auto_d && ($urandom_range(99) < d_pct)) begin
          d_we    = 1'($urandom_range(1));
          d_addr  = rand_addr();
          d_wdata = $urandom;
          d_wstrb = 4'($urandom_range(15));
          d_req   = 1'b1;
        end
      end
      if_kill   = (kill_cnt != kill_done) || (auto_kill && ($urandom_range(99) < kill_pct));
      kill_done = kill_cnt;
    end
  end

  // ---------------- behavioural memory ----------------
  bit          hs = 0, pend = 0;
  logic        hs_we;
  logic [31:0] hs_addr, hs_wdata, prd, w;
  logic [3:0]  hs_wstrb;
  int          pcnt = 0, vcnt = 0;

  initial begin : memory
    forever begin
      @(negedge clock);
      if (!reset && m_valid && m_ready) begin
        hs = 1; hs_we = m_we; hs_addr = m_addr; hs_wdata = m_wdata; hs_wstrb = m_wstrb;
      end
      @(posedge clock);
      #1;
      if (hs) begin
        hs = 0;
        if (hs_we) begin
          w = mem_word(hs_addr);
          for (int i = 0; i < 4; i++) if (hs_wstrb[i]) w[8*i +: 8] = hs_wdata[8*i +: 8];
          mem_arr[hs_addr >> 2] = w;
          prd = $urandom;
        end else begin
          prd = mem_word(hs_addr);
        end
        pend = 1;
        pcnt = int'($urandom_range(resp_max, resp_min)) - 1;
      end
      m_rvalid = 1'b0;
      m_rdata  = $urandom;
      if (pend) begin
        if (pcnt == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = prd;
          pend     = 0;
        end else begin
          pcnt--;
        end
      end
      if (m_valid) begin
        m_ready = (stall_k >= 0) ? (vcnt >= stall_k) : ($urandom_range(99) < rdy_pct);
        vcnt++;
      end else begin
        vcnt    = 0;
        m_ready = 1'($urandom_range(1));
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  int    phase = 0;      // 0 idle, 1 command outstanding, 2 awaiting response
  int    cur;
  int    streak = 0;
  bit    owner_if = 1, killed = 0;
  bit    ei, ed;
  logic  eirv, edrv;
  logic [31:0] eird, edrd, nw;
  cmd_t  cmd_q[$];
  resp_t resp_q[$];
  resp_t r;

  always @(negedge clock) begin
    g_if = if_gnt;
    g_d  = d_gnt;
    if (reset) begin
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      phase = 0; streak = 0; killed = 0; owner_if = 1;
      cmd_q.delete();
      resp_q.delete();
    end else begin
      cur = phase;
      ei = 0; ed = 0;
      if (cur == 0 && (if_req || d_req)) begin
        ei = if_req && (!d_req || streak == 4);
        ed = !ei;
        if (ei) begin
          cmd_q.push_back('{1'b0, if_addr, 32'h0, 4'h0});
          resp_q.push_back('{1'b1, ref_rd(if_addr)});
          streak = 0;
          owner_if = 1;
        end else begin
          cmd_q.push_back('{d_we, d_addr, d_wdata, d_wstrb});
          if (d_we) begin
            nw = ref_rd(d_addr);
            for (int i = 0; i < 4; i++) if (d_wstrb[i]) nw[8*i +: 8] = d_wdata[8*i +: 8];
            ref_mem[d_addr >> 2] = nw;
            resp_q.push_back('{1'b0, 32'h0});
          end else begin
            resp_q.push_back('{1'b0, ref_rd(d_addr)});
          end
          streak = if_req ? ((streak < 15) ? streak + 1 : 15) : 0;
          owner_if = 0;
        end
        phase = 1;
      end
      chk("if_gnt", if_gnt, ei);
      chk("d_gnt", d_gnt, ed);
      chk("m_valid", m_valid, cur == 1);
      if (cur == 1) begin
        chk("m_we", m_we, cmd_q[0].we);
        chk("m_addr", m_addr, cmd_q[0].addr);
        chk("m_wdata", m_wdata, cmd_q[0].wdata);
        chk("m_wstrb", m_wstrb, cmd_q[0].wstrb);
        if (m_ready) begin
          void'(cmd_q.pop_front());
          phase = 2;
        end
      end
      eirv = 0; edrv = 0; eird = '0; edrd = '0;
      if (cur == 2 && m_rvalid) begin
        r = resp_q.pop_front();
        if (r.is_if) begin
          eirv = !(killed || if_kill);
          eird = eirv ? r.data : 32'h0;
        end else begin
          edrv = 1;
          edrd = r.data;
        end
        phase  = 0;
        killed = 0;
      end else if (cur != 0 && owner_if && if_kill) begin
        killed = 1;
      end
      chk("if_rvalid", if_rvalid, eirv);
      chk("if_rdata", if_rdata, eird);
      chk("d_rvalid", d_rvalid, edrv);
      chk("d_rdata", d_rdata, edrd);
    end
  end

  // ---------------- sequence ----------------
  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (!(phase == 0 && !if_req && !d_req && !pend && if_todo.size() == 0 &&
                 d_todo.size() == 0) && n < 300);
    if (n >= 300) chk({"drain_timeout_", tag}, 1, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_phase2(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (phase != 2 && n < 100);
    if (n >= 100) chk({"phase_timeout_", tag}, 1, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_wstrb"}, m_wstrb, 0);
    chk({tag, "_if_gnt"}, if_gnt, 0);
    chk({tag, "_d_gnt"}, d_gnt, 0);
    chk({tag, "_if_rvalid"}, if_rvalid, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  initial begin
    ref_mem[32'h10 >> 2] = 32'h0050_0093;
    mem_arr[32'h10 >> 2] = 32'h0050_0093;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    #1;
    chk_all_zero("reset");

    // Best-case fetch, then simultaneous fetch/load.
    if_todo.push_back(32'h10);
    wait_idle("fetch");
    d_todo.push_back('{1'b0, 32'h100, 32'h0, 4'h0});
    if_todo.push_back(32'h40);
    wait_idle("simul");

    // Both requesters held continuously: streak bound exercised.
    auto_if = 1; auto_d = 1; if_pct = 100; d_pct = 100;
    repeat (60) @(negedge clock);
    auto_if = 0; auto_d = 0;
    wait_idle("streak");

    // Store with a three-cycle m_ready stall.
    stall_k = 3;
    d_todo.push_back('{1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF});
    wait_idle("store");
    stall_k = -1;

    // Kill a fetch while waiting, then fetch normally.
    resp_min = 3; resp_max = 3;
    if_todo.push_back(32'h10);
    wait_phase2("kill");
    kill_cnt++;
    wait_idle("kill");
    if_todo.push_back(32'h10);
    wait_idle("after_kill");

    // Randomised traffic with stalls, variable latency and stray kills.
    auto_if = 1; auto_d = 1; auto_kill = 1;
    if_pct = 40; d_pct = 40; kill_pct = 5; rdy_pct = 60; resp_min = 1; resp_max = 4;
    repeat (3000) @(negedge clock);
    auto_if = 0; auto_d = 0; auto_kill = 0;
    wait_idle("random");

    // Reset while waiting; the late response lands in IDLE and must be ignored.
    rdy_pct = 100; resp_min = 2; resp_max = 2;
    if_todo.push_back(32'h80);
    wait_phase2("rst_mid");
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    #1;
    chk_all_zero("rst_mid");
    d_todo.push_back('{1'b0, 32'h100, 32'h0, 4'h0});
    if_todo.push_back(32'h10);
    wait_idle("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
